// File: rtl/pixel_readout_pkg.sv
// Shared types and helpers for the pixel readout controller.
package pixel_readout_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_N_PIX  = 4;

  typedef enum logic [2:0] {
    S_WAIT_ERASE,
    S_ERASE,
    S_WAIT_EXPOSE,
    S_WAIT_CONVERT,
    S_CONVERT,
    S_WAIT_READ,
    S_READ
  } state_t;

  // Binary to Gray conversion; callers cast to their own width.
  function automatic logic [31:0] gray_enc(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/pix_stream_reg.sv
// Single-entry valid/ready output register with load, hold and flush.
module pix_stream_reg #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              flush,
  input  logic [DATA_W-1:0] load_data,
  input  logic              ready,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              xfer_c
);

  assign xfer_c = valid & ready;

  // Flush wins over load; a transfer empties the entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      data  <= load_data;
      valid <= 1'b1;
    end else if (xfer_c) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pixel_readout_ctrl.sv
// Sensor-side phase follower: Gray ramp during convert, pixel streaming during
// read, and phase-order checking.
module pixel_readout_ctrl
  import pixel_readout_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned N_PIX  = DEF_N_PIX,
  parameter int unsigned IDX_W  = $clog2(N_PIX)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              erase,
  input  logic              expose,
  input  logic              convert,
  input  logic              read,
  output logic [DATA_W-1:0] ramp_code,
  output logic [IDX_W-1:0]  pix_sel,
  input  logic [DATA_W-1:0] pix_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_done,
  output logic              seq_err,
  output logic              ovr_err
);

  localparam logic [DATA_W-1:0] RAMP_MAX = '1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_PIX - 1);

  state_t            state_q, state_d;
  logic              erase_q, expose_q;
  logic [DATA_W-1:0] cnt_q;
  logic [1:0]        lat_q;
  logic              xfer_c, multi_c, erase_rise_c;
  logic              seq_set_c, ovr_set_c, err_clr_c, done_c;
  logic              load_c, flush_c;

  assign multi_c      = $countones({erase, expose, convert, read}) > 1;
  assign erase_rise_c = erase & ~erase_q;

  // Next-state and error/done decisions.
  always_comb begin
    state_d   = state_q;
    seq_set_c = 1'b0;
    ovr_set_c = 1'b0;
    err_clr_c = 1'b0;
    done_c    = 1'b0;
    if (multi_c) begin
      seq_set_c = 1'b1;
      state_d   = S_WAIT_ERASE;
    end else if (erase_rise_c && state_q != S_WAIT_ERASE && state_q != S_ERASE) begin
      state_d = S_ERASE;
    end else begin
      case (state_q)
        S_WAIT_ERASE: if (erase) begin
          state_d   = S_ERASE;
          err_clr_c = erase_rise_c;
        end
        S_ERASE:
          if (convert | read) begin seq_set_c = 1'b1; state_d = S_WAIT_ERASE; end
          else if (!erase)    state_d = S_WAIT_EXPOSE;
        S_WAIT_EXPOSE:
          if (convert | read)         begin seq_set_c = 1'b1; state_d = S_WAIT_ERASE; end
          else if (expose_q & ~expose) state_d = S_WAIT_CONVERT;
        S_WAIT_CONVERT:
          if (expose | read) begin seq_set_c = 1'b1; state_d = S_WAIT_ERASE; end
          else if (convert)  state_d = S_CONVERT;
        S_CONVERT:
          if (expose)        begin seq_set_c = 1'b1; state_d = S_WAIT_ERASE; end
          else if (!convert) state_d = S_WAIT_READ;
        S_WAIT_READ:
          if (expose | convert) begin seq_set_c = 1'b1; state_d = S_WAIT_ERASE; end
          else if (read)        state_d = S_READ;
        S_READ:
          if (xfer_c && pix_sel == LAST_IDX) begin done_c = 1'b1; state_d = S_WAIT_ERASE; end
          else if (expose | convert) begin seq_set_c = 1'b1; state_d = S_WAIT_ERASE; end
          else if (!read)            begin ovr_set_c = 1'b1; state_d = S_WAIT_ERASE; end
        default: state_d = S_WAIT_ERASE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_WAIT_ERASE;
      erase_q    <= 1'b0;
      expose_q   <= 1'b0;
      frame_done <= 1'b0;
      seq_err    <= 1'b0;
      ovr_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      erase_q    <= erase;
      expose_q   <= expose;
      frame_done <= done_c;
      if (seq_set_c)      seq_err <= 1'b1;
      else if (err_clr_c) seq_err <= 1'b0;
      if (ovr_set_c)      ovr_err <= 1'b1;
      else if (err_clr_c) ovr_err <= 1'b0;
    end
  end

  // Ramp counter saturates; the Gray code trails it by one register stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      ramp_code <= '0;
    end else begin
      if (state_d == S_CONVERT && state_q != S_CONVERT)
        cnt_q <= '0;
      else if (state_q == S_CONVERT && convert && cnt_q != RAMP_MAX)
        cnt_q <= cnt_q + DATA_W'(1);
      ramp_code <= DATA_W'(gray_enc(32'(cnt_q)));
    end
  end

  // lat_q covers memory latency: load two cycles after pix_sel moves.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_sel <= '0;
      lat_q   <= '0;
    end else if (state_d != S_READ) begin
      pix_sel <= '0;
      lat_q   <= '0;
    end else if (state_q != S_READ) begin
      pix_sel <= '0;
      lat_q   <= 2'b01;
    end else if (xfer_c) begin
      pix_sel <= pix_sel + IDX_W'(1);
      lat_q   <= 2'b01;
    end else begin
      lat_q   <= {lat_q[0], 1'b0};
    end
  end

  assign load_c  = lat_q[1] && state_q == S_READ;
  assign flush_c = state_d != S_READ;

  pix_stream_reg #(.DATA_W(DATA_W)) u_stream (
    .clk       (clk),
    .reset     (reset),
    .load      (load_c),
    .flush     (flush_c),
    .load_data (pix_data),
    .ready     (out_ready),
    .data      (out_data),
    .valid     (out_valid),
    .xfer_c    (xfer_c)
  );

endmodule

// File: tb/tb_pixel_readout_ctrl.sv
// Directed bench for pixel_readout_ctrl with a scoreboard on the pixel stream.
module tb_pixel_readout_ctrl;
  import pixel_readout_pkg::*;

  logic       clk, reset, erase, expose, convert, read, out_ready;
  logic [7:0] ramp_code, pix_data, out_data;
  logic [1:0] pix_sel;
  logic       out_valid, frame_done, seq_err, ovr_err;

  logic [7:0] mem [0:3] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] exp_q [$];
  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;

  pixel_readout_ctrl #(.DATA_W(8), .N_PIX(4), .IDX_W(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .erase      (erase),
    .expose     (expose),
    .convert    (convert),
    .read       (read),
    .ramp_code  (ramp_code),
    .pix_sel    (pix_sel),
    .pix_data   (pix_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frame_done (frame_done),
    .seq_err    (seq_err),
    .ovr_err    (ovr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pixel memory with one cycle of read latency.
  always @(posedge clk) pix_data <= mem[pix_sel];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] g8(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

  // Transfers complete at the next posedge; inputs are stable since the last one.
  always @(negedge clk) begin
    if (frame_done === 1'b1) done_cnt++;
    if (reset && out_valid === 1'b1 && out_ready === 1'b1) begin
      check("word_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 40 && out_valid !== 1'b1; i++) cyc(1);
    check(tag, 32'(out_valid), 32'd1);
  endtask

  task automatic rest_phases(input int conv_len);
    expose = 1'b1; cyc(10); expose = 1'b0; cyc(2);
    convert = 1'b1; cyc(conv_len); convert = 1'b0; cyc(2);
  endtask

  task automatic run_phases(input int conv_len);
    erase = 1'b1; cyc(5); erase = 1'b0; cyc(2);
    rest_phases(conv_len);
  endtask

  task automatic push_frame();
    for (int i = 0; i < 4; i++) exp_q.push_back(mem[i]);
  endtask

  initial begin
    int d0;
    int bad;
    logic seen7, stable;
    reset = 1'b0; erase = 1'b0; expose = 1'b0; convert = 1'b0; read = 1'b0; out_ready = 1'b0;
    cyc(2);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ramp", 32'(ramp_code), 32'd0);
    check("rst_errs", 32'({seq_err, ovr_err, frame_done}), 32'd0);
    check("rst_state", 32'(dut.state_q), 32'(S_WAIT_ERASE));
    reset = 1'b1; cyc(2);

    // Nominal frame, always ready.
    out_ready = 1'b1;
    run_phases(20);
    check("ramp_after_20", 32'(ramp_code), 32'h1A); // gray(19)
    d0 = done_cnt;
    push_frame();
    read = 1'b1; cyc(100); read = 1'b0; cyc(2);
    check("nom_done", 32'(done_cnt - d0), 32'd1);
    check("nom_drained", 32'(exp_q.size()), 32'd0);
    check("nom_errs", 32'({seq_err, ovr_err}), 32'd0);
    check("nom_state", 32'(dut.state_q), 32'(S_WAIT_ERASE));

    // Long convert: ramp saturates at 255.
    erase = 1'b1; cyc(5); erase = 1'b0; cyc(2);
    expose = 1'b1; cyc(10); expose = 1'b0; cyc(2);
    convert = 1'b1; cyc(2);
    check("ramp_start", 32'(ramp_code), 32'd0);
    bad = 0; seen7 = 1'b0;
    for (int i = 1; i <= 298; i++) begin
      cyc(1);
      if (ramp_code !== g8(8'(i > 255 ? 255 : i))) bad++;
      if (ramp_code === 8'h07) seen7 = 1'b1;
    end
    convert = 1'b0; cyc(1);
    check("ramp_seq", 32'(bad), 32'd0);
    check("ramp_seen_07", 32'(seen7), 32'd1);
    check("ramp_sat", 32'(ramp_code), 32'h80);
    cyc(5);
    check("ramp_hold", 32'(ramp_code), 32'h80);
    d0 = done_cnt;
    push_frame();
    read = 1'b1; cyc(20); read = 1'b0; cyc(2);
    check("sat_done", 32'(done_cnt - d0), 32'd1);

    // Erase rising during READ aborts without error, then a backpressured frame.
    run_phases(20);
    out_ready = 1'b0; d0 = done_cnt;
    read = 1'b1;
    wait_valid("abort_valid");
    read = 1'b0; erase = 1'b1; cyc(1);
    check("abort_valid_low", 32'(out_valid), 32'd0);
    check("abort_state", 32'(dut.state_q), 32'(S_ERASE));
    check("abort_errs", 32'({seq_err, ovr_err}), 32'd0);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    cyc(4); erase = 1'b0; cyc(2);
    rest_phases(20);
    push_frame();
    read = 1'b1;
    wait_valid("bp_valid0");
    out_ready = 1'b1; cyc(1); out_ready = 1'b0;
    wait_valid("bp_valid1");
    stable = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (!(out_valid === 1'b1 && out_data === 8'h22)) stable = 1'b0;
      cyc(1);
    end
    check("bp_stable", 32'(stable), 32'd1);
    out_ready = 1'b1; cyc(20); read = 1'b0; cyc(2);
    check("bp_done", 32'(done_cnt - d0), 32'd1);
    check("bp_drained", 32'(exp_q.size()), 32'd0);

    // Read phase too short: overrun.
    run_phases(20);
    out_ready = 1'b0; d0 = done_cnt;
    read = 1'b1; cyc(4);
    check("ovr_pre_valid", 32'(out_valid), 32'd1);
    read = 1'b0; cyc(1);
    check("ovr_flag", 32'(ovr_err), 32'd1);
    check("ovr_valid_low", 32'(out_valid), 32'd0);
    check("ovr_no_done", 32'(done_cnt - d0), 32'd0);
    out_ready = 1'b1;
    run_phases(20);
    check("ovr_cleared", 32'(ovr_err), 32'd0);
    push_frame();
    read = 1'b1; cyc(20); read = 1'b0; cyc(2);
    check("rec_done", 32'(done_cnt - d0), 32'd1);
    check("rec_drained", 32'(exp_q.size()), 32'd0);

    // Two phases high at once, then convert out of order.
    convert = 1'b1; read = 1'b1; cyc(1); convert = 1'b0; read = 1'b0;
    check("multi_seq", 32'(seq_err), 32'd1);
    erase = 1'b1; cyc(2);
    check("seq_cleared", 32'(seq_err), 32'd0);
    erase = 1'b0; cyc(2);
    convert = 1'b1; cyc(1);
    check("order_seq", 32'(seq_err), 32'd1);
    check("order_state", 32'(dut.state_q), 32'(S_WAIT_ERASE));
    convert = 1'b0; cyc(2);

    // Asynchronous reset in the middle of READ.
    run_phases(20);
    out_ready = 1'b0;
    read = 1'b1;
    wait_valid("rstmid_valid");
    @(negedge clk); reset = 1'b0; #1;
    check("rstmid_valid_low", 32'(out_valid), 32'd0);
    check("rstmid_data", 32'(out_data), 32'd0);
    check("rstmid_ramp", 32'(ramp_code), 32'd0);
    check("rstmid_sel_errs", 32'({pix_sel, seq_err, ovr_err, frame_done}), 32'd0);
    @(negedge clk); reset = 1'b1;
    cyc(5);
    check("rstmid_wait", 32'(dut.state_q), 32'(S_WAIT_ERASE));
    check("rstmid_no_valid", 32'(out_valid), 32'd0);
    read = 1'b0;
    out_ready = 1'b1; d0 = done_cnt;
    run_phases(20);
    push_frame();
    read = 1'b1; cyc(20); read = 1'b0; cyc(2);
    check("post_rst_done", 32'(done_cnt - d0), 32'd1);
    check("post_rst_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
